// File: rtl/ibex_bridge_pkg.sv
// Shared types and constants for the Ibex data-side SRAM bridge.
// Optional feature macro: IBEX_DATA_BRIDGE_RDATA_MASK_EN (byte-masked read data).
package ibex_bridge_pkg;

  localparam int unsigned BRIDGE_MAX_OUTSTANDING_LIMIT = 4;
  localparam logic [31:0] BRIDGE_ERR_RDATA             = 32'h0;

  // One tracked transaction; the byte enables are only kept when read masking is built in.
  typedef struct packed {
    logic       err;
    logic       we;
`ifdef IBEX_DATA_BRIDGE_RDATA_MASK_EN
    logic [3:0] be;
`endif
  } resp_entry_t;

endpackage

// File: rtl/ibex_bridge_resp_fifo.sv
// In-order response tracking FIFO for the data SRAM bridge.
// Supports push and pop in the same cycle; push when full and pop when empty are ignored.
module ibex_bridge_resp_fifo
  import ibex_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  resp_entry_t                  entry_i,
  input  logic                         pop_i,
  output resp_entry_t                  head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t         mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Entry storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_data_sram_bridge.sv
// Bridges the Ibex data req/gnt/rvalid port to one on-chip SRAM with in-order,
// variable read latency. Out-of-window accesses complete with data_err_o.
// Optional feature macro: IBEX_DATA_BRIDGE_RDATA_MASK_EN (zero unselected read bytes).
module ibex_data_sram_bridge
  import ibex_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
  parameter int unsigned SIZE_BYTES      = 65536,
  parameter int unsigned SRAM_AW         = $clog2(SIZE_BYTES / 4),
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               data_req_i,
  output logic               data_gnt_o,
  input  logic               data_we_i,
  input  logic [3:0]         data_be_i,
  input  logic [31:0]        data_addr_i,
  input  logic [31:0]        data_wdata_i,
  output logic               data_rvalid_o,
  output logic [31:0]        data_rdata_o,
  output logic               data_err_o,
  output logic               sram_req_o,
  input  logic               sram_gnt_i,
  output logic               sram_we_o,
  output logic [3:0]         sram_be_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic               sram_rvalid_i,
  input  logic [31:0]        sram_rdata_i
);

  localparam int unsigned CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] WIN_MASK = ~(SIZE_BYTES - 32'd1);

  logic              in_win, credit, push, pop;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     count;
  resp_entry_t       push_entry, head;
  logic              rvalid_q, err_q;
  logic [31:0]       rdata_q, rdata_d;

  assign in_win = ((data_addr_i & WIN_MASK) == BASE_ADDR);
  // count is start-of-cycle occupancy, so a pop in this cycle never frees a credit early
  assign credit = (count < CW'(MAX_OUTSTANDING)) & ~fifo_full;

  assign sram_req_o   = rst_ni & data_req_i & in_win & credit;
  assign data_gnt_o   = rst_ni & data_req_i & credit & (~in_win | sram_gnt_i);
  assign sram_we_o    = data_we_i;
  assign sram_be_o    = data_be_i;
  assign sram_wdata_o = data_wdata_i;
  assign sram_addr_o  = SRAM_AW'((data_addr_i - BASE_ADDR) >> 2);

  assign push = data_gnt_o;

  // Build the tracking entry for the access being granted.
  always_comb begin
    push_entry     = '0;
    push_entry.err = ~in_win;
    push_entry.we  = data_we_i;
`ifdef IBEX_DATA_BRIDGE_RDATA_MASK_EN
    push_entry.be  = data_be_i;
`endif
  end

  ibex_bridge_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Retire the head: error entries immediately, SRAM entries on sram_rvalid_i; stray responses drop.
  always_comb begin
    pop     = ~fifo_empty & (head.err | sram_rvalid_i);
    rdata_d = BRIDGE_ERR_RDATA;
    if (pop && !head.err && !head.we) begin
`ifdef IBEX_DATA_BRIDGE_RDATA_MASK_EN
      for (int unsigned i = 0; i < 4; i++) begin
        rdata_d[8*i +: 8] = head.be[i] ? sram_rdata_i[8*i +: 8] : 8'h00;
      end
`else
      rdata_d = sram_rdata_i;
`endif
    end
  end

  // Registered response to the core; one-cycle pulse per retired entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pop;
      err_q    <= pop & head.err;
      rdata_q  <= rdata_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;

endmodule
